// File: rtl/axil_regbank_proc_if.sv
// AXI4-Lite bus bundle for axil_regbank_proc: five channels with master/slave views.
interface axil_regbank_proc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) ();
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_regbank_proc.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed data registers plus a write-count STATUS word.
// Build macro AXIL_INV_VIEW_EN adds a read-only inverted view of the data registers above STATUS.
module axil_regbank_proc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_regbank_proc_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_full_reg;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic                  w_full_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [NBYTES-1:0]     w_strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [DATA_WIDTH-1:0] wcount_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_ok;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic [1:0]            rd_resp_next;

  // Byte-offset address bits carry no meaning for a word-wide bank.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.AWADDR, bus.ARADDR};

  // Readies come from registered flags; reset only gates them so they are low for its whole duration.
  assign bus.AWREADY = !aw_full_reg && !ARESET;
  assign bus.WREADY  = !w_full_reg && !ARESET;
  assign bus.ARREADY = !rvalid_reg && !ARESET;
  assign bus.BVALID  = bvalid_reg;
  assign bus.BRESP   = bresp_reg;
  assign bus.RVALID  = rvalid_reg;
  assign bus.RDATA   = rdata_reg;
  assign bus.RRESP   = rresp_reg;

  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID && bus.WREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign commit = aw_full_reg && w_full_reg && (!bvalid_reg || bus.BREADY);
  assign wr_ok  = aw_idx_reg < STATUS_IDX;
  assign ar_idx = bus.ARADDR[ADDR_WIDTH-1:LSB];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_reg <= 1'b0;
      aw_idx_reg  <= '0;
    end else if (aw_hs) begin
      aw_full_reg <= 1'b1;
      aw_idx_reg  <= bus.AWADDR[ADDR_WIDTH-1:LSB];
    end else if (commit) begin
      aw_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_full_reg <= 1'b0;
      w_data_reg <= '0;
      w_strb_reg <= '0;
    end else if (w_hs) begin
      w_full_reg <= 1'b1;
      w_data_reg <= bus.WDATA;
      w_strb_reg <= bus.WSTRB;
    end else if (commit) begin
      w_full_reg <= 1'b0;
    end
  end

  // A commit on the B handshake edge keeps BVALID high and replaces BRESP.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bus.BREADY) begin
      bvalid_reg <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wcount_reg <= '0;
    end else if (commit && wr_ok) begin
      wcount_reg <= wcount_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  sel;

    assign sel = commit && (aw_idx_reg == IDX_W'(gi));

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        data_reg <= '0;
      end else if (sel) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (w_strb_reg[b]) begin
            data_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
          end
        end
      end
    end

    assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
  end

  // Read decode uses pre-edge register state, so a same-edge commit is not visible.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_data_next = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        rd_resp_next = RESP_OKAY;
      end
    end
    if (ar_idx == STATUS_IDX) begin
      rd_data_next = wcount_reg;
      rd_resp_next = RESP_OKAY;
    end
`ifdef AXIL_INV_VIEW_EN
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(NUM_REGS + 1 + i)) begin
        rd_data_next = ~regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        rd_resp_next = RESP_OKAY;
      end
    end
`else
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data_next;
      rresp_reg  <= rd_resp_next;
    end else if (bus.RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_regbank_proc.sv
// Scoreboard bench for axil_regbank_proc: directed writes/reads push expected B/R beats, a monitor pops them.
module tb_axil_regbank_proc;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic         aclk;
  logic         areset;
  logic [127:0] regs_q;

  axil_regbank_proc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  axil_regbank_proc #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .bus    (bus.slave),
    .regs_q (regs_q)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] b_q[$];
  rexp_t      r_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a beat seen valid&&ready at the falling edge completes at the next rising edge.
  always @(negedge aclk) begin
    logic [1:0] be;
    rexp_t      re;
    if (!areset && bus.BVALID && bus.BREADY) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_beat: unexpected B beat bresp=%0b, expected none", bus.BRESP);
      end else begin
        be = b_q.pop_front();
        $display("B beat: bresp=%0b expected=%0b", bus.BRESP, be);
        check("bresp", 64'(bus.BRESP), 64'(be));
      end
    end
    if (!areset && bus.RVALID && bus.RREADY) begin
      if (r_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_beat: unexpected R beat rresp=%0b rdata=0x%0h, expected none", bus.RRESP, bus.RDATA);
      end else begin
        re = r_q.pop_front();
        $display("R beat: rresp=%0b rdata=0x%08h expected %0b/0x%08h", bus.RRESP, bus.RDATA, re.resp, re.data);
        check("rresp", 64'(bus.RRESP), 64'(re.resp));
        check("rdata", 64'(bus.RDATA), 64'(re.data));
      end
    end
  end

  // Drive AW and/or W until each requested channel handshakes; returns #1 after the last handshake edge.
  task automatic send(input bit do_aw, input bit do_w, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bit aw_done = !do_aw;
    bit w_done  = !do_w;
    bit aw_go, w_go;
    bus.AWADDR = a;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    bus.AWVALID = do_aw;
    bus.WVALID  = do_w;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge aclk);
      aw_go = bus.AWVALID && bus.AWREADY;
      w_go  = bus.WVALID && bus.WREADY;
      @(posedge aclk);
      #1;
      if (aw_go) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  bus.WVALID  = 1'b0; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_timeout: addr=0x%0h aw_done=%0b w_done=%0b, required both 1", a, aw_done, w_done);
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
    end
  endtask

  task automatic write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] exp_resp);
    b_q.push_back(exp_resp);
    send(1'b1, 1'b1, a, d, s);
  endtask

  task automatic read(input logic [5:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    int n = 0;
    bit go = 0;
    rexp_t e;
    e.resp = exp_resp;
    e.data = exp_data;
    r_q.push_back(e);
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    while (!go && n < 50) begin
      @(negedge aclk);
      go = bus.ARREADY;
      @(posedge aclk);
      #1;
      n++;
    end
    bus.ARVALID = 1'b0;
    if (!go) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_timeout: addr=0x%0h arready never seen, required 1", a);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    cycles(3);
    check("rst_regs", 64'(|regs_q), 64'd0);
    check("rst_bvalid", 64'(bus.BVALID), 64'd0);
    check("rst_rvalid", 64'(bus.RVALID), 64'd0);
    check("rst_awready", 64'(bus.AWREADY), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("rel_awready", 64'(bus.AWREADY), 64'd1);
    check("rel_arready", 64'(bus.ARREADY), 64'd1);
    @(posedge aclk);
    #1;

    // 1: simultaneous AW+W, one-edge commit latency
    write(6'h04, 32'hA5A5_1234, 4'hF, OKAY);
    check("t1_bvalid_before_commit", 64'(bus.BVALID), 64'd0);
    cycles(1);
    check("t1_bvalid_after_commit", 64'(bus.BVALID), 64'd1);
    check("t1_reg1", 64'(regs_q[63:32]), 64'hA5A5_1234);
    cycles(1);
    read(6'h10, OKAY, 32'd1);
    cycles(2);

    // 2: W three cycles ahead of AW, single-byte merge
    write(6'h00, 32'hDEAD_BEEF, 4'hF, OKAY);
    cycles(2);
    send(1'b0, 1'b1, 6'h00, 32'h0000_00FF, 4'b0001);
    cycles(3);
    check("t2_no_commit_w_only", 64'(bus.BVALID), 64'd0);
    check("t2_wready_full", 64'(bus.WREADY), 64'd0);
    check("t2_reg0_before", 64'(regs_q[31:0]), 64'hDEAD_BEEF);
    b_q.push_back(OKAY);
    send(1'b1, 1'b0, 6'h00, 32'h0, 4'h0);
    cycles(1);
    check("t2_bvalid_pulse", 64'(bus.BVALID), 64'd1);
    cycles(1);
    check("t2_bvalid_single", 64'(bus.BVALID), 64'd0);
    check("t2_reg0_merged", 64'(regs_q[31:0]), 64'hDEAD_BEFF);

    // 3: B stall blocks the second commit until the B handshake
    bus.BREADY = 1'b0;
    write(6'h0C, 32'h1111_2222, 4'hF, OKAY);
    cycles(6);
    check("t3_bvalid_held", 64'(bus.BVALID), 64'd1);
    write(6'h08, 32'h3333_4444, 4'hF, OKAY);
    cycles(2);
    check("t3_reg2_not_committed", 64'(regs_q[95:64]), 64'd0);
    check("t3_awready_full", 64'(bus.AWREADY), 64'd0);
    check("t3_wready_full", 64'(bus.WREADY), 64'd0);
    bus.BREADY = 1'b1;
    cycles(1);
    check("t3_bvalid_back_to_back", 64'(bus.BVALID), 64'd1);
    check("t3_reg2", 64'(regs_q[95:64]), 64'h3333_4444);
    check("t3_reg3", 64'(regs_q[127:96]), 64'h1111_2222);
    cycles(1);
    check("t3_bvalid_clear", 64'(bus.BVALID), 64'd0);
    read(6'h10, OKAY, 32'd5);
    cycles(2);

    // 4: STATUS, inverted-view and unmapped writes are rejected
    write(6'h10, 32'h1, 4'hF, SLVERR);
    cycles(2);
    write(6'h3C, 32'h1, 4'hF, SLVERR);
    cycles(2);
    write(6'h14, 32'hFFFF_FFFF, 4'hF, SLVERR);
    cycles(2);
    read(6'h3C, SLVERR, 32'h0);
    cycles(2);
    read(6'h10, OKAY, 32'd5);
    cycles(2);
    check("t4_reg0_untouched", 64'(regs_q[31:0]), 64'hDEAD_BEFF);

    // 5: R stall holds data; inverted view
    write(6'h04, 32'h0F0F_0F0F, 4'hF, OKAY);
    cycles(2);
    bus.RREADY = 1'b0;
    read(6'h04, OKAY, 32'h0F0F_0F0F);
    for (int i = 0; i < 4; i++) begin
      check("t5_rvalid_held", 64'(bus.RVALID), 64'd1);
      check("t5_arready_low", 64'(bus.ARREADY), 64'd0);
      check("t5_rdata_stable", 64'(bus.RDATA), 64'h0F0F_0F0F);
      cycles(1);
    end
    bus.RREADY = 1'b1;
    cycles(1);
    check("t5_rvalid_clear", 64'(bus.RVALID), 64'd0);
`ifdef AXIL_INV_VIEW_EN
    read(6'h18, OKAY, 32'hF0F0_F0F0);
`else
    read(6'h18, SLVERR, 32'h0);
`endif
    cycles(2);
    read(6'h10, OKAY, 32'd6);
    cycles(2);

    // 6: reset right after AW+W handshake drops the pending write
    send(1'b1, 1'b1, 6'h00, 32'h1234_5678, 4'hF);
    areset = 1'b1;
    @(negedge aclk);
    check("t6_awready_in_reset", 64'(bus.AWREADY), 64'd0);
    check("t6_wready_in_reset", 64'(bus.WREADY), 64'd0);
    check("t6_arready_in_reset", 64'(bus.ARREADY), 64'd0);
    @(posedge aclk);
    #1;
    check("t6_bvalid_no_commit", 64'(bus.BVALID), 64'd0);
    check("t6_regs_cleared", 64'(|regs_q), 64'd0);
    cycles(1);
    areset = 1'b0;
    @(negedge aclk);
    check("t6_awready_release", 64'(bus.AWREADY), 64'd1);
    check("t6_wready_release", 64'(bus.WREADY), 64'd1);
    check("t6_arready_release", 64'(bus.ARREADY), 64'd1);
    @(posedge aclk);
    #1;
    cycles(2);
    check("t6_bvalid_after", 64'(bus.BVALID), 64'd0);
    check("t6_regs_still_zero", 64'(|regs_q), 64'd0);
    read(6'h10, OKAY, 32'd0);

    n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 20) begin
      cycles(1);
      n++;
    end
    check("b_queue_drained", 64'(b_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
